regbank_access_ctrl: RTL and testbench

- Initiator side of the 16x32 register bank read/write interface.
- Accepts decoded operand requests (rs1, rs2, rd) over a valid/ready handshake, drives the bank read ports, and presents captured operands downstream one cycle later.
- Sequences writebacks onto the bank write port through a one-cycle write stage.
- Keeps a 16-bit scoreboard so RAW and WAW hazards stall instead of reading stale data.

---
 rtl/regbank_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_regbank_access_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_access_ctrl.sv
// Initiator-side access controller for a 2**AW x DW register bank: operand reads, one-cycle writeback stage
// and a RAW/WAW scoreboard. Optional REGBANK_BYPASS_EN forwards the in-flight writeback to waiting sources.
module regbank_access_ctrl #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_rs1,
   input  logic [AW-1:0] in_rs2,
   input  logic          in_use1,
   input  logic          in_use2,
   input  logic [AW-1:0] in_rd,
   input  logic          in_wb,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_op1,
   output logic [DW-1:0] out_op2,
   output logic [AW-1:0] out_rd,
   output logic          out_wb,
   input  logic          wb_valid,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   output logic [AW-1:0] rad1,
   output logic [AW-1:0] rad2,
   output logic          r1,
   output logic          r2,
   input  logic [DW-1:0] rdata1,
   input  logic [DW-1:0] rdata2,
   output logic [AW-1:0] wad,
   output logic [DW-1:0] wdata,
   output logic          wen
);

   localparam int unsigned NREG = 1 << AW;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t          r_state, w_state_nxt;
   logic [NREG-1:0] r_busy, w_busy_nxt;
   logic            r_wen;
   logic [AW-1:0]   r_wad;
   logic [DW-1:0]   r_wdata;
   logic [DW-1:0]   r_op1, r_op2;
   logic [AW-1:0]   r_rd;
   logic            r_wb;
   logic            w_byp1, w_byp2, w_hz, w_ready, w_acc;
   logic [DW-1:0]   w_op1, w_op2;

`ifdef REGBANK_BYPASS_EN
   // r_wen implies r_wad != 0, so register 0 is never forwarded
   assign w_byp1 = r_wen && (r_wad == in_rs1);
   assign w_byp2 = r_wen && (r_wad == in_rs2);
`else
   assign w_byp1 = 1'b0;
   assign w_byp2 = 1'b0;
`endif

   // Sources are checked against the current scoreboard, before this request's own set
   assign w_hz = (in_use1 & r_busy[in_rs1] & ~w_byp1)
               | (in_use2 & r_busy[in_rs2] & ~w_byp2)
               | (in_wb   & r_busy[in_rd]);

   assign w_ready  = ((r_state == EMPTY) || out_ready) && !w_hz;
   assign w_acc    = in_valid && w_ready;
   assign in_ready = w_ready;

   assign rad1 = in_rs1;
   assign rad2 = in_rs2;
   assign r1   = w_acc && in_use1;
   assign r2   = w_acc && in_use2;

   always_comb begin
      w_op1 = '0;
      w_op2 = '0;
      if (in_use1 && (in_rs1 != '0)) w_op1 = w_byp1 ? r_wdata : rdata1;
      if (in_use2 && (in_rs2 != '0)) w_op2 = w_byp2 ? r_wdata : rdata2;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= EMPTY;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY:   if (w_acc) w_state_nxt = FULL;
         FULL:    if (out_ready && !w_acc) w_state_nxt = EMPTY;
         default: w_state_nxt = EMPTY;
      endcase
   end

   // Output bundle only changes on accept, so it holds under backpressure
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op1 <= '0;
         r_op2 <= '0;
         r_rd  <= '0;
         r_wb  <= 1'b0;
      end else if (w_acc) begin
         r_op1 <= w_op1;
         r_op2 <= w_op2;
         r_rd  <= in_rd;
         r_wb  <= in_wb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wen   <= 1'b0;
         r_wad   <= '0;
         r_wdata <= '0;
      end else begin
         r_wen <= wb_valid && (wb_addr != '0);
         if (wb_valid) begin
            r_wad   <= wb_addr;
            r_wdata <= wb_data;
         end
      end
   end

   // Clear applied first so a same-cycle set on the same address wins
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_wen) w_busy_nxt[r_wad] = 1'b0;
      if (w_acc && in_wb && (in_rd != '0)) w_busy_nxt[in_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) r_busy <= '0;
      else     r_busy <= w_busy_nxt;
   end

   assign out_valid = (r_state == FULL);
   assign out_op1   = r_op1;
   assign out_op2   = r_op2;
   assign out_rd    = r_rd;
   assign out_wb    = r_wb;
   assign wen       = r_wen;
   assign wad       = r_wad;
   assign wdata     = r_wdata;

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Directed self-checking bench for regbank_access_ctrl with a behavioural 16x32 bank model.
module tb_regbank_access_ctrl;

   logic        clk, rst;
   logic        in_valid, in_ready, in_use1, in_use2, in_wb;
   logic [3:0]  in_rs1, in_rs2, in_rd;
   logic        out_valid, out_ready, out_wb;
   logic [31:0] out_op1, out_op2;
   logic [3:0]  out_rd;
   logic        wb_valid;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data;
   logic [3:0]  rad1, rad2, wad;
   logic        r1, r2, wen;
   wire  [31:0] rdata1, rdata2;
   logic [31:0] wdata;
   logic [31:0] bank [16];

   int tests  = 0;
   int failed = 0;

   regbank_access_ctrl #(.DW(32), .AW(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_use1(in_use1), .in_use2(in_use2), .in_rd(in_rd), .in_wb(in_wb),
      .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
      .out_rd(out_rd), .out_wb(out_wb),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .rad1(rad1), .rad2(rad2), .r1(r1), .r2(r2), .rdata1(rdata1), .rdata2(rdata2),
      .wad(wad), .wdata(wdata), .wen(wen)
   );

   // Bank model: register 0 holds a nonzero pattern so forced-zero reads are visible
   assign rdata1 = r1 ? bank[rad1] : {32{1'bz}};
   assign rdata2 = r2 ? bank[rad2] : {32{1'bz}};

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) bank[i] <= 32'hA5A50000 | 32'(i);
      end else if (wen) begin
         bank[wad] <= wdata;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_rs1 = 4'd0; in_rs2 = 4'd0; in_use1 = 1'b0; in_use2 = 1'b0;
      in_rd = 4'd0; in_wb = 1'b0; wb_valid = 1'b0; wb_addr = 4'd0; wb_data = 32'd0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      in_use1 = 1'b1; in_rs1 = 4'd6; in_wb = 1'b1; in_rd = 4'd6;
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
      tests++; if (out_op1 !== 32'd0) begin failed++; $display("FAIL rst_out_op1: got %h exp 0", out_op1); end
      tests++; if (out_op2 !== 32'd0) begin failed++; $display("FAIL rst_out_op2: got %h exp 0", out_op2); end
      tests++; if (out_rd !== 4'd0 || out_wb !== 1'b0) begin failed++; $display("FAIL rst_out_rd_wb: got %h/%b exp 0/0", out_rd, out_wb); end
      tests++; if (wen !== 1'b0 || wad !== 4'd0 || wdata !== 32'd0) begin failed++; $display("FAIL rst_write: got %b/%h/%h exp 0/0/0", wen, wad, wdata); end
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
      tests++; if (r1 !== 1'b0) begin failed++; $display("FAIL rst_r1_idle: got %b exp 0", r1); end
      idle();
      tick();
   endtask

   task automatic test_read();
      wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 32'h1234;
      tick();
      wb_valid = 1'b0;
      @(negedge clk);
      tests++; if (wen !== 1'b1 || wad !== 4'd5 || wdata !== 32'h1234) begin failed++; $display("FAIL rd_wstage: got %b/%h/%h exp 1/5/1234", wen, wad, wdata); end
      tick();
      in_valid = 1'b1; in_rs1 = 4'd5; in_rs2 = 4'd0; in_use1 = 1'b1; in_use2 = 1'b1; in_rd = 4'd1;
      @(negedge clk);
      tests++; if (in_ready !== 1'b1 || r1 !== 1'b1 || r2 !== 1'b1) begin failed++; $display("FAIL rd_drive: got rdy=%b r1=%b r2=%b exp 1/1/1", in_ready, r1, r2); end
      tests++; if (rad1 !== 4'd5 || rad2 !== 4'd0) begin failed++; $display("FAIL rd_addr: got %h/%h exp 5/0", rad1, rad2); end
      tick();
      idle();
      @(negedge clk);
      tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL rd_out_valid: got %b exp 1", out_valid); end
      tests++; if (out_op1 !== 32'h1234) begin failed++; $display("FAIL rd_op1: got %h exp 1234", out_op1); end
      tests++; if (out_op2 !== 32'd0) begin failed++; $display("FAIL rd_op2_r0: got %h exp 0", out_op2); end
      tests++; if (out_rd !== 4'd1 || out_wb !== 1'b0) begin failed++; $display("FAIL rd_pass: got %h/%b exp 1/0", out_rd, out_wb); end
      tick();
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rd_drain: got %b exp 0", out_valid); end
      tick();
   endtask

   task automatic test_reg0();
      in_valid = 1'b1; in_rd = 4'd0; in_wb = 1'b1;
      wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 32'hFFFF;
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL r0_accept: got %b exp 1", in_ready); end
      tick();
      idle();
      in_use1 = 1'b1; in_rs1 = 4'd0; in_wb = 1'b1; in_rd = 4'd0;
      @(negedge clk);
      tests++; if (wen !== 1'b0) begin failed++; $display("FAIL r0_wb_drop: wen got %b exp 0", wen); end
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL r0_never_busy: got %b exp 1", in_ready); end
      idle();
      tick(); tick();
   endtask

   task automatic test_raw();
      in_valid = 1'b1; in_rd = 4'd7; in_wb = 1'b1;
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL raw_producer: got %b exp 1", in_ready); end
      tick();
      in_wb = 1'b0; in_rd = 4'd0; in_use1 = 1'b1; in_rs1 = 4'd7;
      @(negedge clk);
      tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL raw_stall0: got %b exp 0", in_ready); end
      tick();
      @(negedge clk);
      tests++; if (in_ready !== 1'b0 || r1 !== 1'b0) begin failed++; $display("FAIL raw_stall1: got rdy=%b r1=%b exp 0/0", in_ready, r1); end
      tick();
      wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'hCAFE0007;
      @(negedge clk);
      tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL raw_stall_wbreq: got %b exp 0", in_ready); end
      tick();
      wb_valid = 1'b0;
      @(negedge clk);
      tests++; if (wen !== 1'b1 || wad !== 4'd7) begin failed++; $display("FAIL raw_wen: got %b/%h exp 1/7", wen, wad); end
`ifdef REGBANK_BYPASS_EN
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL raw_bypass_accept: got %b exp 1", in_ready); end
`else
      tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL raw_wen_stall: got %b exp 0", in_ready); end
      tick();
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL raw_release: got %b exp 1", in_ready); end
`endif
      tick();
      idle();
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || out_op1 !== 32'hCAFE0007) begin failed++; $display("FAIL raw_op1: got v=%b op1=%h exp 1/cafe0007", out_valid, out_op1); end
      tick();
   endtask

   task automatic test_waw();
      in_valid = 1'b1; in_rd = 4'd4; in_wb = 1'b1;
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL waw_first: got %b exp 1", in_ready); end
      tick();
      @(negedge clk);
      tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL waw_stall: got %b exp 0", in_ready); end
      tick();
      wb_valid = 1'b1; wb_addr = 4'd4; wb_data = 32'h44;
      @(negedge clk);
      tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL waw_stall_wbreq: got %b exp 0", in_ready); end
      tick();
      wb_valid = 1'b0;
      @(negedge clk);
      tests++; if (in_ready !== 1'b0 || wen !== 1'b1) begin failed++; $display("FAIL waw_wen_stall: got rdy=%b wen=%b exp 0/1", in_ready, wen); end
      tick();
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL waw_release: got %b exp 1", in_ready); end
      tick();
      idle();
      in_use1 = 1'b1; in_rs1 = 4'd4;
      @(negedge clk);
      tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL waw_busy_end: got %b exp 0", in_ready); end
      wb_valid = 1'b1; wb_addr = 4'd4; wb_data = 32'h444;
      tick();
      wb_valid = 1'b0;
      tick();
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL waw_cleared: got %b exp 1", in_ready); end
      idle();
      tick();
   endtask

   task automatic test_backpressure();
      in_valid = 1'b1; in_rs1 = 4'd5; in_use1 = 1'b1; in_rd = 4'd2;
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL bp_first: got %b exp 1", in_ready); end
      tick();
      out_ready = 1'b0; in_rs1 = 4'd0; in_use1 = 1'b0; in_rd = 4'd3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++; if (out_valid !== 1'b1 || out_op1 !== 32'h1234 || out_rd !== 4'd2) begin failed++; $display("FAIL bp_hold%0d: got v=%b op1=%h rd=%h exp 1/1234/2", i, out_valid, out_op1, out_rd); end
         tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL bp_ready%0d: got %b exp 0", i, in_ready); end
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL bp_release: got %b exp 1", in_ready); end
      tick();
      idle();
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || out_rd !== 4'd3 || out_op1 !== 32'd0) begin failed++; $display("FAIL bp_replace: got v=%b rd=%h op1=%h exp 1/3/0", out_valid, out_rd, out_op1); end
      tick();
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL bp_drain: got %b exp 0", out_valid); end
      tick();
   endtask

   task automatic test_same_cycle();
      wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 32'h99;
      tick();
      wb_valid = 1'b0;
      in_valid = 1'b1; in_rd = 4'd9; in_wb = 1'b1;
      @(negedge clk);
      tests++; if (wen !== 1'b1 || wad !== 4'd9 || in_ready !== 1'b1) begin failed++; $display("FAIL sc_accept: got wen=%b wad=%h rdy=%b exp 1/9/1", wen, wad, in_ready); end
      tick();
      idle();
      in_use1 = 1'b1; in_rs1 = 4'd9;
      @(negedge clk);
      tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL sc_set_wins: got %b exp 0", in_ready); end
      wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 32'h999;
      tick();
      wb_valid = 1'b0;
      tick();
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL sc_cleared: got %b exp 1", in_ready); end
      idle();
      tick();
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; in_rd = 4'd3; in_wb = 1'b1; out_ready = 1'b0;
      wb_valid = 1'b1; wb_addr = 4'd6; wb_data = 32'h66;
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL rm_accept: got %b exp 1", in_ready); end
      tick();
      idle();
      out_ready = 1'b0; in_wb = 1'b1; in_rd = 4'd3;
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || wen !== 1'b1 || in_ready !== 1'b0) begin failed++; $display("FAIL rm_pre: got v=%b wen=%b rdy=%b exp 1/1/0", out_valid, wen, in_ready); end
      rst = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      tests++; if (out_valid !== 1'b0 || wen !== 1'b0) begin failed++; $display("FAIL rm_post: got v=%b wen=%b exp 0/0", out_valid, wen); end
      tests++; if (out_rd !== 4'd0 || out_wb !== 1'b0) begin failed++; $display("FAIL rm_out_clr: got %h/%b exp 0/0", out_rd, out_wb); end
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL rm_sb_clr: got %b exp 1", in_ready); end
      idle();
      tick();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_read();
      test_reg0();
      test_raw();
      test_waw();
      test_backpressure();
      test_same_cycle();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
